demux1x4_64bit_stream: RTL and testbench
========================================

Name: demux1x4_64bit_stream

Overview:
Registered 1-to-4 distributor for 64-bit data words. It is the counterpart of the 4:1 64-bit select mux: it takes one upstream stream and routes each word, by a 2-bit select, to one of four downstream consumers. Each output has its own one-entry output register with a valid/ready handshake, so the four destinations stall independently. It sits between a single producer (e.g. a load/writeback path) and four per-lane consumers.

Parameters:
DW, 64, data width of input and each output
CW, 16, width of each per-channel beat counter (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear: drops all held output words and counters
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept the upstream word this cycle
in_data  input  DW  upstream word
in_sel  input  2  destination channel for in_data, sampled with in_valid
out_valid  output  4  per-channel output valid, bit k = channel k
out_ready  input  4  per-channel downstream ready
out_data0..out_data3  output  DW each  per-channel held data word
beat_cnt  output  4*CW  per-channel accepted-beat counters, channel k at [k*CW +: CW]

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 4'b0000, all out_dataK = 0, beat_cnt = 0. in_ready then evaluates to 1.
- Transfer rules: an input beat happens when in_valid & in_ready. An output beat on channel k happens when out_valid[k] & out_ready[k].
- in_ready = ~clr & (~out_valid[in_sel] | out_ready[in_sel]). It is combinational from in_sel, out_valid and out_ready. It never depends on in_valid.
- On an input beat with in_sel = k: out_dataK <= in_data and out_valid[k] <= 1 on the next edge. Latency is one cycle, input edge to out_valid.
- Per-channel two-state FSM: EMPTY -> FULL on an input beat. FULL -> EMPTY on an output beat with no simultaneous input beat to the same channel. FULL -> FULL on an input beat and output beat in the same cycle (pass-through: the new word replaces the old one, no bubble).
- Sustained throughput is 1 word/cycle to any channel whose consumer holds out_ready = 1.
- While out_valid[k] = 1 and out_ready[k] = 0, out_dataK and out_valid[k] stay stable. Channels other than in_sel are never modified by an input beat.
- Output beats on different channels may occur in the same cycle.
- out_dataK keeps its last value after out_valid[k] drops. Consumers must not rely on it.
- in_sel and in_data changing while in_valid = 1 and in_ready = 0 is allowed. The block samples only on a beat.
- clr high: on the next edge out_valid = 0 and beat_cnt = 0; out_dataK is unchanged. in_ready = 0 while clr is high, so no input beat is accepted in that cycle. clr overrides simultaneous output beats; those words are lost.
- rst_n asserted mid-transfer: held words are discarded immediately. There is no recovery of in-flight data.

Optional Feature:
Macro DEMUX_BEAT_CNT_EN.
- Defined: each channel has a CW-bit counter that increments on every input beat routed to it. Counters saturate at all-ones and do not wrap. They clear on reset or clr and are driven on beat_cnt.
- Not defined: no counter registers are built and beat_cnt is tied to 0.
- Handshake and data behaviour are identical in both builds.

Test Plan:
- Reset release, all out_ready = 1 -> out_valid = 0000 and in_ready = 1. Send in_data = 64'hDEAD_BEEF_0000_0001 with in_sel = 2 -> next cycle out_valid = 0100 and out_data2 = 64'hDEAD_BEEF_0000_0001.
- out_ready[1] = 0, send A to channel 1, then present B to channel 1 -> in_ready = 0 and out_data1 holds A. Raise out_ready[1] -> A is consumed and B is accepted in the same cycle. out_data1 = B the next cycle with no bubble.
- Channel 0 stalled and full, present a word for channel 3 -> in_ready = 1 and the word is accepted. out_data0 and out_valid[0] are unchanged.
- 100 back-to-back beats, in_sel = i mod 4, all ready = 1 -> 100 output beats in order per channel, one per cycle. With DEMUX_BEAT_CNT_EN each counter reads 25.
- Fill all four channels with ready = 0, pulse clr for 1 cycle -> out_valid = 0000 and beat_cnt = 0; in_ready = 0 during the clr cycle.
- Build with DEMUX_BEAT_CNT_EN and CW = 4, send 20 beats to channel 0 -> beat_cnt[3:0] saturates at 4'hF. Build without the macro -> beat_cnt = 0 throughout.

Source files
------------

// File: rtl/demux1x4_64bit_stream_if.sv
// Upstream/downstream handshake bundle for the 1:4 64-bit stream distributor.
// slave = distributor side, master = producer/consumer (environment) side.
interface demux1x4_64bit_stream_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;

  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data0;
  logic [DW-1:0] out_data1;
  logic [DW-1:0] out_data2;
  logic [DW-1:0] out_data3;

  logic [4*CW-1:0] beat_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, beat_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, beat_cnt
  );
endinterface

// File: rtl/demux1x4_64bit_stream.sv
// Registered 1-to-4 distributor: each upstream word is steered by in_sel into
// one of four one-entry output registers, each with its own valid/ready.
// Optional per-channel saturating beat counters: define DEMUX_BEAT_CNT_EN.
module demux1x4_64bit_stream #(
  parameter int unsigned DW = 64,
  parameter int unsigned CW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  demux1x4_64bit_stream_if.slave    bus
);

  localparam int unsigned NCH = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  ch_state_e     st_q   [NCH];
  logic [DW-1:0] data_q [NCH];

  logic [NCH-1:0] valid_c;
  logic [NCH-1:0] in_hit_c;
  logic [NCH-1:0] out_beat_c;
  logic           in_ready_c;
  logic           in_beat_c;

  // Channel valid is simply the FULL state of its FSM.
  always_comb begin
    valid_c = '0;
    for (int k = 0; k < NCH; k++) begin
      valid_c[k] = (st_q[k] == ST_FULL);
    end
  end

  // Accept when the selected slot is empty or draining this cycle; clr blocks input.
  assign in_ready_c = ~clr & (~valid_c[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign in_beat_c  = bus.in_valid & in_ready_c;
  assign out_beat_c = valid_c & bus.out_ready;

  // One-hot steering of the input beat to its destination channel.
  always_comb begin
    in_hit_c = '0;
    for (int k = 0; k < NCH; k++) begin
      in_hit_c[k] = in_beat_c & (bus.in_sel == 2'(k));
    end
  end

  // Per-channel EMPTY/FULL FSM and data register; a new word wins over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k]   <= ST_EMPTY;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (clr) begin
          st_q[k] <= ST_EMPTY;
        end else if (in_hit_c[k]) begin
          st_q[k]   <= ST_FULL;
          data_q[k] <= bus.in_data;
        end else if (out_beat_c[k]) begin
          st_q[k] <= ST_EMPTY;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_c;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];

`ifdef DEMUX_BEAT_CNT_EN
  logic [CW-1:0]     cnt_q [NCH];
  logic [NCH*CW-1:0] cnt_vec_c;

  // Saturating count of input beats accepted per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (clr) begin
          cnt_q[k] <= '0;
        end else if (in_hit_c[k] && (cnt_q[k] != {CW{1'b1}})) begin
          cnt_q[k] <= cnt_q[k] + CW'(1);
        end
      end
    end
  end

  // Pack the counters, channel k at [k*CW +: CW].
  always_comb begin
    cnt_vec_c = '0;
    for (int k = 0; k < NCH; k++) begin
      cnt_vec_c[k*CW +: CW] = cnt_q[k];
    end
  end

  assign bus.beat_cnt = cnt_vec_c;
`else
  localparam int unsigned CNT_W = NCH * CW;

  assign bus.beat_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_demux1x4_64bit_stream.sv
// Bench for the 1:4 64-bit stream distributor: directed scenarios plus random
// traffic, checked against a per-channel queue model of accepted words.
module tb_demux1x4_64bit_stream;

  localparam int unsigned DW   = 64;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  logic clr;

  int total;
  int bad;

  // Model: words accepted but not yet consumed, last word written, beat counts.
  logic [DW-1:0] q    [4][$];
  logic [DW-1:0] last [4];
  int            cnt  [4];

  demux1x4_64bit_stream_if #(.DW(DW), .CW(CW)) bus ();

  demux1x4_64bit_stream #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] obs_data(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic [4*CW-1:0] exp_cnt_vec();
    logic [4*CW-1:0] v;
    v = '0;
`ifdef DEMUX_BEAT_CNT_EN
    for (int k = 0; k < 4; k++) v[k*CW +: CW] = CW'(cnt[k]);
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last[k] = '0;
      cnt[k]  = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                       input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  // One clock: compare DUT against the model, then advance the model on the edge.
  task automatic step();
    logic [3:0]    mv;
    logic [3:0]    ob;
    logic          mr;
    logic          ib;
    logic [1:0]    s;
    logic [DW-1:0] d;
    logic          c;
    #1;
    for (int k = 0; k < 4; k++) mv[k] = (q[k].size() != 0);
    s  = bus.in_sel;
    d  = bus.in_data;
    c  = clr;
    mr = !c && (!mv[s] || bus.out_ready[s]);
    check("in_ready", 64'(bus.in_ready), 64'(mr));
    check("out_valid", 64'(bus.out_valid), 64'(mv));
    for (int k = 0; k < 4; k++) check($sformatf("out_data%0d", k), 64'(obs_data(k)), 64'(last[k]));
    check("beat_cnt", 64'(bus.beat_cnt), 64'(exp_cnt_vec()));
    ib = bus.in_valid && mr;
    ob = mv & bus.out_ready;
    @(posedge clk);
    if (c) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) if (ob[k]) void'(q[k].pop_front());
      if (ib) begin
        q[s].push_back(d);
        last[s] = d;
        if (cnt[s] < CMAX) cnt[s]++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [4*CW-1:0] ev;
    int              e;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 2'd0, '0, 4'hF);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'(4'b0000));
    check("rst_ready", 64'(bus.in_ready), 64'(1'b1));
    check("rst_cnt", 64'(bus.beat_cnt), 64'(0));
    check("rst_data2", 64'(bus.out_data2), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // First word to channel 2, visible one cycle later.
    drive(1'b1, 2'd2, 64'hDEAD_BEEF_0000_0001, 4'hF);
    step();
    drive(1'b0, 2'd0, '0, 4'hF);
    #1;
    check("t1_valid", 64'(bus.out_valid), 64'(4'b0100));
    check("t1_data2", 64'(bus.out_data2), 64'hDEAD_BEEF_0000_0001);
    step();

    // Stall on channel 1, then pass-through with no bubble.
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hFEDC_BA98_7654_3210;
    drive(1'b1, 2'd1, a, 4'b1101);
    step();
    drive(1'b1, 2'd1, b, 4'b1101);
    #1;
    check("t2_stall_rdy", 64'(bus.in_ready), 64'(1'b0));
    check("t2_hold_a", 64'(bus.out_data1), 64'(a));
    step();
    drive(1'b1, 2'd1, b, 4'hF);
    #1;
    check("t2_pass_rdy", 64'(bus.in_ready), 64'(1'b1));
    step();
    drive(1'b0, 2'd0, '0, 4'b1101);
    #1;
    check("t2_data_b", 64'(bus.out_data1), 64'(b));
    check("t2_valid1", 64'(bus.out_valid[1]), 64'(1'b1));
    step();
    drive(1'b0, 2'd0, '0, 4'hF);
    step();

    // Stalled full channel 0 does not block channel 3.
    drive(1'b1, 2'd0, a, 4'b1110);
    step();
    drive(1'b1, 2'd3, b, 4'b1110);
    #1;
    check("t3_rdy", 64'(bus.in_ready), 64'(1'b1));
    step();
    drive(1'b0, 2'd0, '0, 4'b1110);
    #1;
    check("t3_data0", 64'(bus.out_data0), 64'(a));
    check("t3_valid", 64'(bus.out_valid), 64'(4'b1001));
    step();
    drive(1'b0, 2'd0, '0, 4'hF);
    step();

    // 100 back-to-back beats round-robin, counters from zero.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 2'(i % 4), {$urandom, $urandom}, 4'hF);
      step();
    end
    drive(1'b0, 2'd0, '0, 4'hF);
    #1;
    e  = (25 > CMAX) ? CMAX : 25;
    ev = '0;
`ifdef DEMUX_BEAT_CNT_EN
    for (int k = 0; k < 4; k++) ev[k*CW +: CW] = CW'(e);
`endif
    check("t4_cnt", 64'(bus.beat_cnt), 64'(ev));
    step();

    // Fill all channels stalled, then a one-cycle clr.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), {$urandom, $urandom}, 4'h0);
      step();
    end
    clr = 1'b1;
    drive(1'b1, 2'd0, {$urandom, $urandom}, 4'h0);
    #1;
    check("t5_clr_rdy", 64'(bus.in_ready), 64'(1'b0));
    step();
    clr = 1'b0;
    drive(1'b0, 2'd0, '0, 4'h0);
    #1;
    check("t5_valid", 64'(bus.out_valid), 64'(4'b0000));
    check("t5_cnt", 64'(bus.beat_cnt), 64'(0));
    step();

    // 20 beats to channel 0 saturate its counter.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd0, {$urandom, $urandom}, 4'hF);
      step();
    end
    drive(1'b0, 2'd0, '0, 4'hF);
    #1;
`ifdef DEMUX_BEAT_CNT_EN
    check("t6_sat", 64'(bus.beat_cnt[CW-1:0]), 64'(CMAX));
`else
    check("t6_sat", 64'(bus.beat_cnt[CW-1:0]), 64'(0));
`endif
    step();

    // Random traffic with occasional clr.
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), {$urandom, $urandom},
            4'($urandom));
      step();
    end
    clr = 1'b0;

    // Asynchronous reset while a word is held.
    drive(1'b1, 2'd1, {$urandom, $urandom}, 4'h0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'(4'b0000));
    check("ar_data1", 64'(bus.out_data1), 64'(0));
    check("ar_cnt", 64'(bus.beat_cnt), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, '0, 4'hF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
